// File: rtl/mul_shift_add_seq.sv
// mul_shift_add_seq
//   Sequential shift-and-add multiplier. One partial product per clock, with an
//   optional early exit once the remaining multiplier bits are all zero.
//   Operands are treated as signed or unsigned, selected at run time. The unit
//   multiplies the magnitudes and negates the result at the end if needed.
//
// Parameters
//   WIDTH       operand width (>= 2); the product is 2*WIDTH bits
//   EARLY_TERM  1: leave CALC when the remaining multiplier is zero
//               0: always spend WIDTH cycles in CALC
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only while idle
//   signed_i  in   1: a_in/b_in are two's complement (latched with start)
//   a_in      in   multiplicand (latched with start)
//   b_in      in   multiplier (latched with start)
//   busy      out  high from the cycle after an accepted start through the done cycle
//   done      out  one-cycle pulse; product is valid from this cycle on
//   product   out  result, held until the next accepted start
module mul_shift_add_seq #(
   parameter int unsigned WIDTH      = 8,
   parameter bit          EARLY_TERM = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 signed_i,
   input  logic [WIDTH-1:0]     a_in,
   input  logic [WIDTH-1:0]     b_in,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int unsigned CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_CALC,
      S_FIN
   } state_t;

   state_t               state_q,   state_d;
   logic [2*WIDTH-1:0]   ma_sh_q,   ma_sh_d;
   logic [WIDTH-1:0]     mb_q,      mb_d;
   logic [2*WIDTH-1:0]   acc_q,     acc_d;
   logic [CW-1:0]        cnt_q,     cnt_d;
   logic                 neg_q,     neg_d;
   logic                 busy_q,    busy_d;
   logic                 done_q,    done_d;
   logic [2*WIDTH-1:0]   product_q, product_d;

   logic [WIDTH-1:0]     a_mag;
   logic [WIDTH-1:0]     b_mag;

   always_comb begin
      // Magnitudes stay unsigned in WIDTH bits, so the most negative value
      // maps onto 2^(WIDTH-1) without overflow.
      a_mag     = (signed_i && a_in[WIDTH-1]) ? -a_in : a_in;
      b_mag     = (signed_i && b_in[WIDTH-1]) ? -b_in : b_in;

      state_d   = state_q;
      ma_sh_d   = ma_sh_q;
      mb_d      = mb_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      neg_d     = neg_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      product_d = product_q;

      unique case (state_q)
         S_IDLE: begin
            // busy_q is still high during the done cycle (state already IDLE);
            // a start seen then is ignored, which gives the one-cycle gap when
            // start is held high.
            if (start && !busy_q) begin
               ma_sh_d   = {{WIDTH{1'b0}}, a_mag};
               mb_d      = b_mag;
               neg_d     = signed_i & (a_in[WIDTH-1] ^ b_in[WIDTH-1]);
               acc_d     = '0;
               cnt_d     = CW'(WIDTH);
               product_d = '0;
               busy_d    = 1'b1;
               state_d   = S_CALC;
            end else begin
               busy_d    = 1'b0;
            end
         end
         S_CALC: begin
            if (mb_q[0]) begin
               acc_d = acc_q + ma_sh_q;
            end
            ma_sh_d = ma_sh_q << 1;
            mb_d    = mb_q >> 1;
            cnt_d   = cnt_q - CW'(1);
            if ((cnt_d == '0) || (EARLY_TERM && (mb_d == '0))) begin
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            product_d = neg_q ? -acc_q : acc_q;
            done_d    = 1'b1;
            state_d   = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         ma_sh_q   <= '0;
         mb_q      <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         neg_q     <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         ma_sh_q   <= ma_sh_d;
         mb_q      <= mb_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         neg_q     <= neg_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         product_q <= product_d;
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign product = product_q;

endmodule
